// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    FULL = 2'b10,
    DROP = 2'b11
  } fetchState_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_J   = 2'b01,
    PC_JR  = 2'b10
  } pcSrc_t;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

  // Word offset of a conditional branch, sign-extended and scaled to bytes.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection for a retiring instruction: sequential, branch, jump or register jump.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] inst_pc4,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic unusedBits;
  assign unusedBits = &{1'b0, inst[31:26], jr_target[1:0]};

  always_comb begin
    next_pc = inst_pc4;
    case (PCSrc)
      PC_J:    next_pc = {inst_pc4[31:28], inst[25:0], 2'b00};
      PC_JR:   next_pc = {jr_target[31:2], 2'b00};
      // PC_SEQ and the unused code 11 both fall through to branch/sequential.
      default: if (Branch && Zero) next_pc = inst_pc4 + branchOffset(inst[15:0]);
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory request, one-entry
// instruction buffer and exception redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)
(
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master imem,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic [31:0]  inst_pc4,
  output logic [5:0]   OpCode,
  output logic [5:0]   Funct,
  input  logic [1:0]   PCSrc,
  input  logic         Branch,
  input  logic         Zero,
  input  logic [31:0]  jr_target,
  input  logic         flush
);

  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] EXC_ADDR   = {EXC_VECTOR[31:2], 2'b00};

  fetchState_t state, stateNext;
  logic [31:0] addrQ, addrNext;
  logic [31:0] pendQ, pendNext;
  logic [31:0] instQ, pcQ, pc4Q;
  logic [31:0] nextPc;
  logic        capture;

  next_pc_calc u_nextPc (
    .inst      (instQ),
    .inst_pc4  (pc4Q),
    .PCSrc     (PCSrc),
    .Branch    (Branch),
    .Zero      (Zero),
    .jr_target (jr_target),
    .next_pc   (nextPc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addrQ <= RESET_ADDR;
      pendQ <= EXC_ADDR;
    end else begin
      state <= stateNext;
      addrQ <= addrNext;
      pendQ <= pendNext;
    end
  end

  always_comb begin
    stateNext = state;
    addrNext  = addrQ;
    pendNext  = pendQ;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        stateNext = REQ;
        addrNext  = RESET_ADDR;
      end
      REQ: begin
        if (imem.imem_ack) begin
          if (flush) begin
            addrNext = EXC_ADDR;
          end else begin
            stateNext = FULL;
            capture   = 1'b1;
          end
        end else if (flush) begin
          stateNext = DROP;
          pendNext  = EXC_ADDR;
        end
      end
      FULL: begin
        if (flush) begin
          stateNext = REQ;
          addrNext  = EXC_ADDR;
        end else if (inst_ready) begin
          stateNext = REQ;
          addrNext  = nextPc;
        end
      end
      DROP: begin
        // Address must stay on the abandoned request until memory answers it.
        if (flush) pendNext = EXC_ADDR;
        if (imem.imem_ack) begin
          stateNext = REQ;
          addrNext  = pendNext;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instQ <= '0;
      pcQ   <= '0;
      pc4Q  <= 32'd4;
    end else if (capture) begin
      instQ <= imem.imem_rdata;
      pcQ   <= addrQ;
      pc4Q  <= addrQ + 32'd4;
    end
  end

  assign imem.imem_req  = (state == REQ) || (state == DROP);
  assign imem.imem_addr = addrQ;
  assign inst_valid     = (state == FULL);
  assign inst           = instQ;
  assign inst_pc        = pcQ;
  assign inst_pc4       = pc4Q;
  assign OpCode         = instQ[31:26];
  assign Funct          = instQ[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a transaction-level fetch model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] EXC = 32'h8000_0180;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  logic        instValid, instReady, flush, Branch, Zero;
  logic [31:0] inst, instPc, instPc4, jrTarget;
  logic [5:0]  OpCode, Funct;
  logic [1:0]  PCSrc;

  fetch_unit #(.RESET_PC(RPC), .EXC_VECTOR(EXC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (bus.master),
    .inst_valid (instValid),
    .inst_ready (instReady),
    .inst       (inst),
    .inst_pc    (instPc),
    .inst_pc4   (instPc4),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .PCSrc      (PCSrc),
    .Branch     (Branch),
    .Zero       (Zero),
    .jr_target  (jrTarget),
    .flush      (flush)
  );

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  bit monOn = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } instRec_t;

  logic [31:0] addrQ[$];
  instRec_t    instQ[$];

  // Model: is a fetch outstanding, will its data be thrown away, is the buffer full.
  bit          mBusy, mDiscard, mFull;
  logic [31:0] mAddr, mInst, mPc;
  int          memCnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNote(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] refNext(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [1:0] src, input logic br,
                                          input logic z, input logic [31:0] jr);
    logic [31:0] pc4;
    int off;
    pc4 = pc + 32'd4;
    if (src == 2'b01) return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (src == 2'b10) return jr & 32'hFFFF_FFFC;
    if (br && z) begin
      off = $signed(ins[15:0]);
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  task automatic issue(input logic [31:0] a);
    mBusy = 1'b1;
    mAddr = a;
    addrQ.push_back(a);
  endtask

  // Choose inputs for the coming rising edge and advance the model across it.
  task automatic step(input bit allowFlush);
    flush     = allowFlush && ($urandom_range(0, 15) == 0);
    instReady = 1'($urandom_range(0, 1));
    PCSrc     = 2'($urandom_range(0, 3));
    Branch    = ($urandom_range(0, 3) != 0);
    Zero      = 1'($urandom_range(0, 1));
    jrTarget  = $urandom;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    if (bus.imem_req) begin
      if (memCnt < 0) memCnt = $urandom_range(0, 3);
      if (memCnt == 0) begin
        bus.imem_ack = 1'b1;
        memCnt = -1;
      end else begin
        memCnt--;
      end
    end
    if (mBusy && bus.imem_ack) begin
      if (flush || mDiscard) begin
        mDiscard = 1'b0;
        issue(EXC);
      end else begin
        mBusy = 1'b0;
        mFull = 1'b1;
        mInst = bus.imem_rdata;
        mPc   = mAddr;
        instQ.push_back('{word: mInst, pc: mPc});
      end
    end else if (mBusy && flush) begin
      mDiscard = 1'b1;
    end else if (mFull && flush) begin
      mFull = 1'b0;
      issue(EXC);
    end else if (mFull && instReady) begin
      mFull = 1'b0;
      issue(refNext(mInst, mPc, PCSrc, Branch, Zero, jrTarget));
    end
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (bus.imem_req && bus.imem_ack) begin
        if (addrQ.size() == 0) failNote("unexpected_request");
        else chk("imem_addr", bus.imem_addr, addrQ.pop_front());
      end
      if (instValid) begin
        chk("req_while_full", 32'(bus.imem_req), 32'd0);
        if (instQ.size() == 0) begin
          failNote("unexpected_inst_valid");
        end else begin
          chk("inst", inst, instQ[0].word);
          chk("inst_pc", instPc, instQ[0].pc);
          chk("inst_pc4", instPc4, instQ[0].pc + 32'd4);
          chk("OpCode", 32'(OpCode), 32'(instQ[0].word[31:26]));
          chk("Funct", 32'(Funct), 32'(instQ[0].word[5:0]));
          if (instReady || flush) begin
            void'(instQ.pop_front());
            delivered++;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    instReady = 1'b0;
    PCSrc = 2'b00;
    Branch = 1'b0;
    Zero = 1'b0;
    jrTarget = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    mBusy = 1'b0;
    mDiscard = 1'b0;
    mFull = 1'b0;
    memCnt = -1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RPC);
    chk("rst_inst_valid", 32'(instValid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", instPc, 32'd0);
    chk("rst_inst_pc4", instPc4, 32'd4);
    chk("rst_OpCode", 32'(OpCode), 32'd0);
    chk("rst_Funct", 32'(Funct), 32'd0);

    // Release with flush high: the first fetch must still go to RESET_PC.
    flush = 1'b1;
    reset = 1'b1;
    issue(RPC);
    monOn = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3000; i++) step(1'b1);

    chk("pending_requests", 32'(addrQ.size() <= 1), 32'd1);
    chk("pending_insts", 32'(instQ.size() <= 1), 32'd1);
    chk("throughput", 32'(delivered >= 300), 32'd1);

    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        if (bus.imem_req) seen = 1'b1;
        else step(1'b0);
      end
      monOn = 1'b0;
      if (!seen) begin
        failNote("timeout_waiting_for_request");
      end else begin
        reset = 1'b0;
        #1;
        chk("async_rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("async_rst_inst_valid", 32'(instValid), 32'd0);
        chk("async_rst_imem_addr", bus.imem_addr, RPC);
        chk("async_rst_inst_pc4", instPc4, 32'd4);
      end
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multi-cycle MIPS core, directly upstream of the `Control` decoder. Holds the PC, runs a req/ack handshake with a variable-latency instruction memory, buffers one fetched instruction, and presents `OpCode`/`Funct` and the raw instruction to decode and execute. When an instruction retires, the block computes the next PC from the decoder's `PCSrc`/`Branch` and the ALU `Zero` flag. An exception flush redirects fetch to a fixed vector.

## Interface
- `RESET_PC`, default 32'h0040_0000: first fetch address after reset.
- `EXC_VECTOR`, default 32'h8000_0180: fetch address after `flush`.

Ports:
- `clk` input 1: clock, rising edge.
- `reset` input 1: active-low asynchronous reset. One clock domain; reset is asynchronous and active-low.
- `imem_req` output 1: fetch request, held until ack.
- `imem_addr` output 32: fetch address, stable while `imem_req`=1, bits [1:0] always 0.
- `imem_ack` input 1: response valid; only meaningful while `imem_req`=1.
- `imem_rdata` input 32: instruction word, valid with `imem_ack`.
- `inst_valid` output 1: buffered instruction present.
- `inst_ready` input 1: consumer retires the instruction this cycle.
- `inst` output 32: buffered instruction.
- `inst_pc` output 32: address of `inst`.
- `inst_pc4` output 32: `inst_pc`+4.
- `OpCode` output 6: `inst[31:26]`.
- `Funct` output 6: `inst[5:0]`.
- `PCSrc` input 2: from `Control`. 00 = sequential/branch, 01 = j/jal, 10 = jr/jalr.
- `Branch` input 1: from `Control`.
- `Zero` input 1: from the ALU.
- `jr_target` input 32: rs register value.
- `flush` input 1: exception redirect.

## Operation
- Retire is `inst_valid & inst_ready`.
- next_pc, evaluated combinationally on retire:
  - `PCSrc`=01: {inst_pc4[31:28], inst[25:0], 2'b00}.
  - `PCSrc`=10: {jr_target[31:2], 2'b00}.
  - `PCSrc`=00, `Branch`=1, `Zero`=1: inst_pc4 + {{14{inst[15]}}, inst[15:0], 2'b00}.
  - Otherwise: inst_pc4.
  - `PCSrc`=11 is treated as 00.
  - All arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFFC is silent.
- FSM states:
  - IDLE: reset state. `imem_req`=0, `inst_valid`=0. Always goes to REQ next cycle with `imem_addr`=RESET_PC.
  - REQ: `imem_req`=1.
    - ack & !flush → FULL; `inst`←imem_rdata, `inst_pc`←imem_addr.
    - flush & ack → response discarded; stay REQ, `imem_addr`←EXC_VECTOR.
    - flush & !ack → DROP; `pend_pc`←EXC_VECTOR.
  - FULL: `inst_valid`=1, `imem_req`=0.
    - flush → REQ, `imem_addr`←EXC_VECTOR. Flush has priority over retire; `inst_ready` is ignored.
    - retire → REQ, `imem_addr`←next_pc.
    - Otherwise hold.
  - DROP: `imem_req`=1 with the old address unchanged.
    - ack → response discarded; REQ with `imem_addr`←pend_pc.
    - Further flushes keep `pend_pc`=EXC_VECTOR.
- At most one request outstanding; no speculative fetch. The buffer is always empty when an ack is accepted.
- Reset values, asserted asynchronously even mid-transaction:
  - `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0.
  - `inst`=0, `inst_pc`=0, `inst_pc4`=4.
  - `OpCode`=0, `Funct`=0.

## Timing
- Retire at cycle t → `imem_req` high at t+1.
- Same-cycle ack at t+1 → `inst_valid` at t+2. Minimum instruction throughput is one per two cycles plus memory latency.
- `inst`, `inst_pc`, `inst_pc4`, `OpCode` and `Funct` are registered and stable while `inst_valid`=1.
- `PCSrc`, `Branch`, `Zero` and `jr_target` are sampled only in the retire cycle.
- `flush` is sampled every cycle. In IDLE, flush is a no-op and the first fetch is RESET_PC.

## Structure
- Shared package:
  - FSM state encodings (IDLE/REQ/FULL/DROP).
  - PCSrc codes (PC_SEQ=00, PC_J=01, PC_JR=10).
  - Default RESET_PC and EXC_VECTOR constants.
- One combinational sub-module, `next_pc_calc`:
  - Inputs: inst, inst_pc4, PCSrc, Branch, Zero, jr_target.
  - Output: next_pc.
  - Owns all target arithmetic.

## Test plan
- Reset release with RESET_PC=0x00400000; ack after 2 cycles with 0x20080005 → `inst_valid`=1, `inst_pc`=0x00400000, `OpCode`=0x08, `Funct`=0x05.
- Retire with `PCSrc`=00, `Branch`=0 → next `imem_addr`=0x00400004. Then retire with `inst_ready` low for 5 cycles → outputs held, no request.
- beq 0x1000FFFF at 0x00400008, `Branch`=1: with `Zero`=1 → next `imem_addr`=0x00400008; with `Zero`=0 → 0x0040000C.
- j 0x08100010 at 0x0040000C → `imem_addr`=0x00400040. jr with `jr_target`=0x00400083 → `imem_addr`=0x00400080.
- `flush` while REQ and ack delayed 3 cycles:
  - `imem_addr` holds the old value until the ack, and the response is discarded.
  - `inst_valid` stays 0.
  - Next request goes to 0x80000180.
- `flush` and `inst_ready` together in FULL → next `imem_addr`=0x80000180. Async `reset` low mid-REQ → `imem_req`=0 and `inst_valid`=0 immediately, before the next clock edge.
